// File: rtl/npc_pkg.sv
// Shared NPC core definitions: datapath widths, reset PC and the fetch packet type.
package npc_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/ifu_ibuf_ptr.sv
// Wrap-bit FIFO pointer: the MSB toggles each lap so full and empty can be told apart.
module ifu_ibuf_ptr #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_r;

  // Pointer register: cleared on reset or flush, otherwise advances modulo 2**W.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      ptr_r <= {W{1'b0}};
    end else if (inc) begin
      ptr_r <= ptr_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/ifu_inst_buffer.sv
// IFU->IDU instruction buffer: DEPTH-entry FIFO of {pc, inst} packets, cleared on redirect.
// Optional same-cycle pass-through when empty is enabled with `define IBUF_BYPASS_EN.
module ifu_inst_buffer
  import npc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = npc_pkg::XLEN,
  parameter int ILEN  = npc_pkg::ILEN
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [ILEN-1:0]          in_inst,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [ILEN-1:0]          out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  fetch_pkt_t     mem_r [DEPTH];
  fetch_pkt_t     head_s;
  logic [PW-1:0]  wptr_s;
  logic [PW-1:0]  rptr_s;
  logic           empty_s;
  logic           full_s;
  logic           enq_s;
  logic           deq_s;
  logic           bypass_s;

  ifu_ibuf_ptr #(.W(PW)) u_wptr (
    .clock (clock),
    .reset (reset),
    .clr   (flush),
    .inc   (enq_s),
    .ptr   (wptr_s)
  );

  ifu_ibuf_ptr #(.W(PW)) u_rptr (
    .clock (clock),
    .reset (reset),
    .clr   (flush),
    .inc   (deq_s),
    .ptr   (rptr_s)
  );

  assign empty_s = (wptr_s == rptr_s);
  assign full_s  = (wptr_s[AW-1:0] == rptr_s[AW-1:0]) && (wptr_s[AW] != rptr_s[AW]);
  assign head_s  = mem_r[rptr_s[AW-1:0]];
  assign count   = wptr_s - rptr_s;

  // in_ready looks only at occupancy, so a dequeue never frees a slot in the same cycle.
  assign in_ready = !full_s && !reset;

`ifdef IBUF_BYPASS_EN
  assign bypass_s = empty_s && in_valid && !flush && !reset;
`else
  assign bypass_s = 1'b0;
`endif

  // Handshake qualification; a pass-through packet is consumed without touching storage.
  always_comb begin
    enq_s = 1'b0;
    deq_s = 1'b0;
    if (flush) begin
      enq_s = 1'b0;
      deq_s = 1'b0;
    end else begin
      enq_s = in_valid && in_ready && !(bypass_s && out_ready);
      deq_s = !empty_s && out_ready;
    end
  end

  // Head presentation: zeroed whenever no packet is offered to decode.
  always_comb begin
    out_valid = 1'b0;
    out_pc    = {XLEN{1'b0}};
    out_inst  = {ILEN{1'b0}};
    if (bypass_s) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_inst  = in_inst;
    end else if (!empty_s && !flush) begin
      out_valid = 1'b1;
      out_pc    = head_s.pc;
      out_inst  = head_s.inst;
    end else begin
      out_valid = 1'b0;
    end
  end

  // Packet storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clock) begin
    if (enq_s) begin
      mem_r[wptr_s[AW-1:0]] <= '{pc: in_pc, inst: in_inst};
    end else begin
      mem_r[wptr_s[AW-1:0]] <= mem_r[wptr_s[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_ifu_inst_buffer.sv
// Self-checking bench for ifu_inst_buffer: directed scenarios plus random backpressure,
// all checked every cycle against a queue-based reference model.
module tb_ifu_inst_buffer;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  ifu_inst_buffer #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } pkt_t;

  pkt_t q[$];
  int   errors    = 0;
  int   checks    = 0;
  int   delivered = 0;
  bit   accepted;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check mid-cycle against the model, then advance the model.
  task automatic cyc(input logic iv, input logic [63:0] pc, input logic [31:0] inst,
                     input logic fl, input logic ordy);
    bit          byp;
    bit          ev;
    bit          enq;
    bit          deq;
    logic [63:0] epc;
    logic [31:0] einst;
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst;
    flush     = fl;
    out_ready = ordy;
    #4;
    byp = 1'b0;
`ifdef IBUF_BYPASS_EN
    byp = (q.size() == 0) && iv && !fl;
`endif
    ev    = ((q.size() != 0) && !fl) || byp;
    epc   = 64'd0;
    einst = 32'd0;
    if (byp) begin
      epc   = pc;
      einst = inst;
    end else if (ev) begin
      epc   = q[0].pc;
      einst = q[0].inst;
    end
    check("out_valid", {63'd0, out_valid}, {63'd0, ev});
    check("in_ready",  {63'd0, in_ready},  {63'd0, (q.size() < DEPTH)});
    check("count",     {61'd0, count},     64'(q.size()));
    check("out_pc",    out_pc,             epc);
    check("out_inst",  {32'd0, out_inst},  {32'd0, einst});
    accepted = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      deq = ev && ordy && !byp;
      enq = iv && (q.size() < DEPTH) && !(byp && ordy);
      if (byp && ordy) begin
        delivered++;
        accepted = 1'b1;
      end
      if (deq) begin
        void'(q.pop_front());
        delivered++;
      end
      if (enq) begin
        q.push_back('{pc, inst});
        accepted = 1'b1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [63:0] pc;
    int          idx;
    int          cycles;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_pc     = 64'd0;
    in_inst   = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    check("rst_in_ready",  {63'd0, in_ready},  64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_count",     {61'd0, count},     64'd0);
    check("rst_out_pc",    out_pc,             64'd0);
    check("rst_out_inst",  {32'd0, out_inst},  64'd0);
    reset = 1'b0;
    q.delete();

    // Single packet through an idle buffer.
    cyc(1'b1, 64'h8000_0000, 32'h0000_0413, 1'b0, 1'b1);
    cyc(1'b0, 64'd0, 32'd0, 1'b0, 1'b1);
    cyc(1'b0, 64'd0, 32'd0, 1'b0, 1'b1);

    // Fill with decode stalled, then offer a fifth packet which must be held off.
    pc = 64'h8000_0000;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, pc, 32'h1000_0000 + pc[31:0], 1'b0, 1'b0);
      if (accepted) pc = pc + 64'd4;
    end
    check("fill_pc_next", pc, 64'h8000_0010);

    // Release decode with fetch still pushing: steady state at count 3.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, pc, 32'h1000_0000 + pc[31:0], 1'b0, 1'b1);
      if (accepted) pc = pc + 64'd4;
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 64'd0, 32'd0, 1'b0, 1'b1);

    // Flush with three buffered plus a concurrent enqueue and dequeue.
    for (int i = 0; i < 3; i++) cyc(1'b1, 64'h8000_0100 + 64'(4 * i), 32'h0000_0013, 1'b0, 1'b0);
    cyc(1'b1, 64'h8000_0FF0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    cyc(1'b1, 64'h8000_1000, 32'h0000_0513, 1'b0, 1'b0);
    cyc(1'b0, 64'd0, 32'd0, 1'b0, 1'b1);
    cyc(1'b0, 64'd0, 32'd0, 1'b0, 1'b1);

    // Empty buffer, packet offered with decode ready (pass-through when bypass is built in).
    cyc(1'b1, 64'h8000_0020, 32'h0000_0093, 1'b0, 1'b1);
    cyc(1'b0, 64'd0, 32'd0, 1'b0, 1'b1);

    // Twenty packets under random backpressure and bursty fetch.
    delivered = 0;
    idx       = 0;
    cycles    = 0;
    while ((idx < 20 || q.size() != 0) && cycles < 400) begin
      if (idx < 20 && $urandom_range(0, 3) != 0) begin
        cyc(1'b1, 64'h8000_2000 + 64'(4 * idx), $urandom, 1'b0, 1'($urandom_range(0, 1)));
        if (accepted) idx++;
      end else begin
        cyc(1'b0, 64'd0, 32'd0, 1'b0, 1'($urandom_range(0, 1)));
      end
      cycles++;
    end
    check("stream_delivered", 64'(delivered), 64'd20);
    check("stream_in_time",   64'(cycles < 400), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifu_inst_buffer.md
Name: ifu_inst_buffer

Overview:
Instruction buffer between the IFU and the IDU.
- Captures fetched {pc, inst} packets from the IFU and holds them in a DEPTH-entry FIFO.
- Presents packets to decode with a valid/ready handshake.
- Decouples fetch from decode stalls.
- Discards all buffered packets on a branch/jump redirect (flush).

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
XLEN, 64, PC width
ILEN, 32, instruction width

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  IFU packet valid
in_ready  output  1  buffer can accept a packet
in_pc  input  XLEN  PC of the fetched instruction
in_inst  input  ILEN  fetched instruction
flush  input  1  redirect; drop all contents
out_valid  output  1  head packet valid to IDU
out_ready  input  1  IDU accepts the head packet
out_pc  output  XLEN  head PC
out_inst  output  ILEN  head instruction
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset:
  - Sampled on posedge clock while high.
  - Write and read pointers cleared to 0; count=0; out_valid=0.
  - out_pc=0 and out_inst=0; in_ready=0 while reset is high.
  - Storage contents are don't-care.
- Pointers:
  - Width $clog2(DEPTH)+1, with the MSB used as the wrap bit.
  - empty = (wptr == rptr).
  - full = index bits equal and wrap bits differ.
- Enqueue:
  - Occurs when in_valid && in_ready && !flush.
  - Writes in_pc/in_inst at wptr; wptr++ wraps naturally modulo 2*DEPTH.
- Dequeue:
  - Occurs when out_valid && out_ready && !flush; rptr++.
- in_ready = !full && !reset.
  - Must not depend on out_ready: no combinational in->out path.
  - When full, a simultaneous dequeue does not permit an enqueue in the same cycle.
- out_valid = !empty && !flush.
  - out_pc/out_inst show the head entry; both are 0 when out_valid=0.
- Ordering and stability:
  - Strict FIFO order.
  - Head outputs are stable while out_valid && !out_ready.
- Latency: 1 cycle minimum. A packet accepted at edge N is visible on out_* after edge N.
- Occupancy:
  - count = wptr - rptr, computed on the full pointer width.
  - Simultaneous enqueue and dequeue leaves count unchanged and is legal at any non-full occupancy.
- Flush:
  - Synchronous; at the next edge wptr=rptr=0 and count=0.
  - An enqueue or dequeue presented in the flush cycle is discarded.
  - out_valid is forced to 0 during the flush cycle.
  - Flush and reset together behave as reset.
- Wrap-around: after 2*DEPTH enqueues the pointers return to 0 with no data corruption.

Optional Feature:
IBUF_BYPASS_EN
- Defined:
  - When empty && in_valid && !flush && !reset, out_valid=1 and out_pc/out_inst = in_pc/in_inst combinationally.
  - If out_ready is also high, the packet passes through with no write, and count stays 0.
  - If out_ready is low, the packet is written normally.
  - In this mode in_ready still equals !full && !reset.
- Not defined: minimum latency 1 cycle, as described in Behaviour.

Decomposition:
- Shared package npc_pkg holds:
  - XLEN=64, ILEN=32, RESET_PC=64'h80000000.
  - typedef fetch_pkt_t {logic [XLEN-1:0] pc; logic [ILEN-1:0] inst;}, used for storage entries.
- Natural sub-module: ifu_ibuf_ptr.
  - Wrap-bit pointer register with inc and clr inputs.
  - Instantiated twice, for write and read.

Test Plan:
- Reset, then single packet in_pc=64'h80000000, in_inst=32'h00000413, out_ready=1 -> out_valid high on the following cycle with the same pc/inst; count goes 1 then 0.
- Fill with out_ready=0 and PCs 80000000, 80000004, 80000008, 8000000C -> in_ready=0 after the 4th accept; count=4; 5th packet (80000010) held off and not written.
- Full, then out_ready=1 with in_valid=1 -> first cycle dequeues only (count 3); afterwards enqueue and dequeue each cycle with count steady at 3; output order 80000000, 80000004, ...
- 3 entries buffered, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0; flush-cycle packet absent; next enqueued 80001000 is the first output.
- 20 packets streamed with random out_ready backpressure (DEPTH=4, multiple pointer wraps) -> scoreboard shows exact in-order delivery; head stable while stalled.
- IBUF_BYPASS_EN defined, empty, in_valid=1 in_pc=64'h80000020, out_ready=1 -> out_valid=1 and out_pc=64'h80000020 in the same cycle; count stays 0.
